// File: rtl/dispatch_buffer.sv
// Dispatch buffer between rename and the dispatch queues: a circular FIFO that
// accepts a compacted group of up to RENAME_WIDTH entries and exposes an in-order head window.
`ifndef RENAME_WIDTH
`define RENAME_WIDTH 4
`endif

package dispatch_buffer_pkg;
  typedef struct packed {
    logic [6:0] pdst;
    logic [6:0] psrc1;
    logic [6:0] psrc2;
    logic [2:0] fu_type;
    logic [7:0] rob_idx;
  } renameInfo_t;
endpackage

module dispatch_buffer
  import dispatch_buffer_pkg::*;
#(
  parameter int unsigned RENAME_WIDTH = `RENAME_WIDTH,
  parameter int unsigned DISP_WIDTH   = 4,
  parameter int unsigned DEPTH        = 16
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 i_squash_vld,
  input  logic        [RENAME_WIDTH-1:0]       i_rename_vld,
  input  renameInfo_t [RENAME_WIDTH-1:0]       i_renameInfo,
  output logic                                 o_stall,
  output logic        [DISP_WIDTH-1:0]         o_disp_vld,
  output renameInfo_t [DISP_WIDTH-1:0]         o_dispInfo,
  input  logic        [DISP_WIDTH-1:0]         i_disp_rdy,
  output logic        [$clog2(DEPTH):0]        o_count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [CW-1:0] STALL_AT = CW'(DEPTH - RENAME_WIDTH);
  localparam logic [CW:0]   DEPTH_W  = (CW + 1)'(DEPTH);

  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;

  renameInfo_t mem_q [DEPTH];

  logic [PW-1:0] enq_off [RENAME_WIDTH];
  logic [CW-1:0] enq_num;
  logic [CW-1:0] enq_add;
  logic [CW-1:0] deq_num;
  logic          deq_run;
  logic          enq_fire;

  // Stall looks only at the registered count, so same-cycle dequeues never release it.
  assign o_stall  = (count_q > STALL_AT);
  assign enq_fire = !o_stall && !i_squash_vld;
  assign o_count  = count_q;

  // Compaction: each valid lane lands at tail plus the number of valid lanes below it.
  always_comb begin
    enq_num = '0;
    for (int l = 0; l < int'(RENAME_WIDTH); l++) begin
      enq_off[l] = enq_num[PW-1:0];
      enq_num    = enq_num + CW'(i_rename_vld[l]);
    end
  end

  assign enq_add = enq_fire ? enq_num : '0;

  always_comb begin
    deq_run = 1'b1;
    deq_num = '0;
    for (int k = 0; k < int'(DISP_WIDTH); k++) begin
      deq_run = deq_run & o_disp_vld[k] & i_disp_rdy[k];
      deq_num = deq_num + CW'(deq_run);
    end
  end

  generate
    for (genvar gi = 0; gi < int'(DISP_WIDTH); gi++) begin : g_disp
      assign o_disp_vld[gi] = (count_q > CW'(gi));
      assign o_dispInfo[gi] = mem_q[head_q + PW'(gi)];
    end
  endgenerate

  always_comb begin
    head_d  = head_q + deq_num[PW-1:0];
    tail_d  = tail_q + enq_add[PW-1:0];
    count_d = count_q + enq_add - deq_num;
    if (i_squash_vld) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Payload storage is never cleared; visibility is governed by count alone.
  always_ff @(posedge clk) begin
    if (enq_fire) begin
      for (int l = 0; l < int'(RENAME_WIDTH); l++) begin
        if (i_rename_vld[l]) begin
          mem_q[tail_q + enq_off[l]] <= i_renameInfo[l];
        end
      end
    end
  end

  logic [CW:0] count_sum;
  assign count_sum = {1'b0, count_q} + {1'b0, enq_add};

  always_ff @(posedge clk) begin
    if (rst && !i_squash_vld) begin
      assert (count_sum - {1'b0, deq_num} <= DEPTH_W);
      assert (deq_num <= count_q);
    end
  end

endmodule

// File: tb/tb_dispatch_buffer.sv
// Self-checking bench for dispatch_buffer: directed scenarios plus random traffic
// compared against a queue-based FIFO reference model.
module tb_dispatch_buffer;
  import dispatch_buffer_pkg::*;

  localparam int DEPTH = 16;
  localparam int RW    = 4;
  localparam int DW    = 4;

  logic                  clk = 1'b0;
  logic                  rst = 1'b0;
  logic                  i_squash_vld = 1'b0;
  logic        [RW-1:0]  i_rename_vld = '0;
  renameInfo_t [RW-1:0]  i_renameInfo = '0;
  logic                  o_stall;
  logic        [DW-1:0]  o_disp_vld;
  renameInfo_t [DW-1:0]  o_dispInfo;
  logic        [DW-1:0]  i_disp_rdy = '0;
  logic        [4:0]     o_count;

  int total = 0;
  int bad   = 0;
  renameInfo_t q[$];

  dispatch_buffer #(.RENAME_WIDTH(RW), .DISP_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst          (rst),
    .i_squash_vld (i_squash_vld),
    .i_rename_vld (i_rename_vld),
    .i_renameInfo (i_renameInfo),
    .o_stall      (o_stall),
    .o_disp_vld   (o_disp_vld),
    .o_dispInfo   (o_dispInfo),
    .i_disp_rdy   (i_disp_rdy),
    .o_count      (o_count)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic renameInfo_t [RW-1:0] rand_info();
    renameInfo_t [RW-1:0] r;
    for (int l = 0; l < RW; l++) r[l] = renameInfo_t'($urandom);
    return r;
  endfunction

  // Compare every output against the reference queue (outputs depend only on state).
  task automatic check_outputs(input string pfx);
    logic [DW-1:0] exp_vld;
    chk({pfx, "_count"}, 64'(o_count), 64'(q.size()));
    chk({pfx, "_stall"}, 64'(o_stall), 64'((DEPTH - q.size()) < RW));
    for (int k = 0; k < DW; k++) exp_vld[k] = (k < q.size());
    chk({pfx, "_vld"}, 64'(o_disp_vld), 64'(exp_vld));
    for (int k = 0; k < DW; k++)
      if (k < q.size())
        chk($sformatf("%s_info%0d", pfx, k), 64'(o_dispInfo[k]), 64'(q[k]));
  endtask

  // One clock of traffic: check, apply edge, update the model by the buffer's rules.
  task automatic step(input string pfx, input logic [RW-1:0] vld, input renameInfo_t [RW-1:0] info,
                      input logic [DW-1:0] rdy, input logic sq);
    int  n;
    bit  stall;
    i_rename_vld = vld;
    i_renameInfo = info;
    i_disp_rdy   = rdy;
    i_squash_vld = sq;
    check_outputs(pfx);
    stall = (DEPTH - q.size()) < RW;
    n = 0;
    for (int k = 0; k < DW; k++) begin
      if (k < q.size() && rdy[k]) n++;
      else break;
    end
    @(posedge clk);
    if (sq) begin
      q.delete();
    end else begin
      repeat (n) void'(q.pop_front());
      if (!stall)
        for (int l = 0; l < RW; l++)
          if (vld[l]) q.push_back(info[l]);
    end
    #1;
    $display("step %s vld=%b rdy=%b sq=%0d -> count=%0d model=%0d", pfx, vld, rdy, sq, o_count, q.size());
  endtask

  initial begin
    renameInfo_t [RW-1:0] e;
    renameInfo_t [RW-1:0] z;
    z = '0;

    // Reset held from time zero
    repeat (2) @(posedge clk);
    #1;
    chk("rst_count", 64'(o_count), 64'(0));
    chk("rst_vld",   64'(o_disp_vld), 64'(0));
    chk("rst_stall", 64'(o_stall), 64'(0));
    rst = 1'b1;

    // Full group of four into an empty buffer
    e = rand_info();
    step("r31", 4'b1111, e, 4'b0000, 1'b0);
    chk("r31_count", 64'(o_count), 64'(4));
    chk("r31_vld",   64'(o_disp_vld), 64'(4'b1111));
    for (int k = 0; k < 4; k++) chk($sformatf("r31_info%0d", k), 64'(o_dispInfo[k]), 64'(e[k]));
    step("flush1", 4'b0000, z, 4'b0000, 1'b1);

    // Sparse lanes are compacted
    e = rand_info();
    step("r32", 4'b1010, e, 4'b0000, 1'b0);
    chk("r32_count", 64'(o_count), 64'(2));
    chk("r32_info0", 64'(o_dispInfo[0]), 64'(e[1]));
    chk("r32_info1", 64'(o_dispInfo[1]), 64'(e[3]));
    step("flush2", 4'b0000, z, 4'b0000, 1'b1);

    // Fill to 13, stall, then drain four
    for (int i = 0; i < 3; i++) step("fill", 4'b1111, rand_info(), 4'b0000, 1'b0);
    step("fill", 4'b0001, rand_info(), 4'b0000, 1'b0);
    chk("r33_stall", 64'(o_stall), 64'(1));
    step("r33_held", 4'b1111, rand_info(), 4'b0000, 1'b0);
    chk("r33_count13", 64'(o_count), 64'(13));
    step("r33_drain", 4'b1111, rand_info(), 4'b1111, 1'b0);
    chk("r33_count9", 64'(o_count), 64'(9));
    chk("r33_unstall", 64'(o_stall), 64'(0));
    step("flush3", 4'b0000, z, 4'b0000, 1'b1);

    // Partial ready: only the all-ready prefix dequeues
    e = rand_info();
    step("r34_fill", 4'b1111, e, 4'b0000, 1'b0);
    step("r34", 4'b0000, z, 4'b1011, 1'b0);
    chk("r34_count", 64'(o_count), 64'(2));
    chk("r34_info0", 64'(o_dispInfo[0]), 64'(e[2]));
    chk("r34_info1", 64'(o_dispInfo[1]), 64'(e[3]));
    step("flush4", 4'b0000, z, 4'b0000, 1'b1);

    // Full-rate streaming; pointers wrap many times
    for (int i = 0; i < 40; i++) step("r35", 4'b1111, rand_info(), 4'b1111, 1'b0);

    // Squash with simultaneous enqueue and dequeue
    step("flush5", 4'b0000, z, 4'b0000, 1'b1);
    step("r36_fill", 4'b1111, rand_info(), 4'b0000, 1'b0);
    step("r36_fill", 4'b1111, rand_info(), 4'b0000, 1'b0);
    step("r36_fill", 4'b0011, rand_info(), 4'b0000, 1'b0);
    chk("r36_count10", 64'(o_count), 64'(10));
    step("r36_sq", 4'b1111, rand_info(), 4'b1111, 1'b1);
    chk("r36_count", 64'(o_count), 64'(0));
    chk("r36_vld",   64'(o_disp_vld), 64'(0));
    chk("r36_stall", 64'(o_stall), 64'(0));

    // Random traffic with occasional squash
    for (int i = 0; i < 300; i++)
      step("rnd", RW'($urandom_range(0, 15)), rand_info(), DW'($urandom_range(0, 15)),
           ($urandom_range(0, 24) == 0));

    // Asynchronous reset mid-stream
    step("pre_rst", 4'b1111, rand_info(), 4'b0000, 1'b0);
    step("pre_rst", 4'b1111, rand_info(), 4'b0001, 1'b0);
    #2;
    rst = 1'b0;
    #1;
    chk("mrst_count", 64'(o_count), 64'(0));
    chk("mrst_vld",   64'(o_disp_vld), 64'(0));
    chk("mrst_stall", 64'(o_stall), 64'(0));
    q.delete();
    @(posedge clk);
    #1;
    rst = 1'b1;
    e = rand_info();
    step("post_rst", 4'b0110, e, 4'b0000, 1'b0);
    chk("post_rst_count", 64'(o_count), 64'(2));
    chk("post_rst_info0", 64'(o_dispInfo[0]), 64'(e[1]));
    step("post_rst2", 4'b0000, z, 4'b0001, 1'b0);
    check_outputs("final");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
